// File: rtl/yport_pkg.sv
// Shared definitions for the Y-port receiver: FSM encoding, widths and the
// saturating counter helper.
package yport_pkg;
    localparam int YDATA_W = 32;
    localparam int CNT_W   = 16;
    localparam int ENTRY_W = YDATA_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        RECOVER = 2'd2
    } yport_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction
endpackage

// File: rtl/yport_if.sv
// Y-port handshake plus the downstream valid/ready stream, bundled as one link.
interface yport_if;
    import yport_pkg::*;

    logic               YREQ;
    logic [YDATA_W-1:0] YDATA;
    logic               YPARITY;
    logic               YACK;
    logic [YDATA_W-1:0] DDATA;
    logic               DERR;
    logic               DVALID;
    logic               DREADY;

    modport master (output YREQ, YDATA, YPARITY, DREADY,
                    input  YACK, DDATA, DERR, DVALID);
    modport slave  (input  YREQ, YDATA, YPARITY, DREADY,
                    output YACK, DDATA, DERR, DVALID);
endinterface

// File: rtl/yport_fifo.sv
// First-word-fall-through FIFO holding {parity_err, data} entries; full/empty
// are derived from the occupancy counter so pointers may wrap freely.
module yport_fifo
    import yport_pkg::*;
#(
    parameter int AWIDTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] rdata_o,
    output logic [AWIDTH:0]    level_o,
    output logic               full_o,
    output logic               empty_o
);
    localparam int               DEPTH   = 2 ** AWIDTH;
    localparam logic [AWIDTH:0]  DEPTH_L = {1'b1, {AWIDTH{1'b0}}};

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AWIDTH-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AWIDTH:0]    level_q, level_d;
    logic               do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == DEPTH_L);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign level_o = level_q;
    // Head reads as zero when empty so the stream outputs are clean after reset.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (do_pop && !do_push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/yport_receiver.sv
// Y-port consumer: YREQ/YACK handshake FSM, word capture into the local FIFO,
// and saturating statistics counters.
module yport_receiver
    import yport_pkg::*;
#(
    parameter int AWIDTH   = 4,
    parameter bit DROP_BAD = 1'b0
) (
    input  logic             HCLK,
    input  logic             HRESET,
    yport_if.slave           yp,
    output logic [CNT_W-1:0] STAT_WORDS,
    output logic [CNT_W-1:0] STAT_PERR,
    output logic [AWIDTH:0]  FIFO_LEVEL
);
    yport_state_e       state_q;
    logic               yack_q;
    logic [CNT_W-1:0]   stat_words_q, stat_words_d;
    logic [CNT_W-1:0]   stat_perr_q, stat_perr_d;
    logic               in_ack, push;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] head;

    assign in_ack       = (state_q == ACK);
    assign push         = in_ack && !(DROP_BAD && yp.YPARITY);
    assign stat_words_d = sat_inc(stat_words_q, in_ack);
    assign stat_perr_d  = sat_inc(stat_perr_q, in_ack && yp.YPARITY);

    // IDLE only commits to an ack when a slot is free, so the ACK-cycle push cannot overflow.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q      <= IDLE;
            yack_q       <= 1'b0;
            stat_words_q <= '0;
            stat_perr_q  <= '0;
        end else begin
            stat_words_q <= stat_words_d;
            stat_perr_q  <= stat_perr_d;
            case (state_q)
                IDLE: begin
                    if (yp.YREQ && !fifo_full) begin
                        state_q <= ACK;
                        yack_q  <= 1'b1;
                    end
                end
                ACK: begin
                    state_q <= RECOVER;
                    yack_q  <= 1'b0;
                end
                RECOVER: state_q <= IDLE;
                default: begin
                    state_q <= IDLE;
                    yack_q  <= 1'b0;
                end
            endcase
        end
    end

    yport_fifo #(.AWIDTH(AWIDTH)) u_fifo (
        .clk_i   (HCLK),
        .rst_i   (HRESET),
        .push_i  (push),
        .wdata_i ({yp.YPARITY, yp.YDATA}),
        .pop_i   (yp.DREADY),
        .rdata_o (head),
        .level_o (FIFO_LEVEL),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign yp.YACK    = yack_q;
    assign yp.DVALID  = !fifo_empty;
    assign yp.DDATA   = head[YDATA_W-1:0];
    assign yp.DERR    = head[YDATA_W];
    assign STAT_WORDS = stat_words_q;
    assign STAT_PERR  = stat_perr_q;
endmodule
